interconn_recv_fifo: RTL and testbench

INTERCONN_RECV_FIFO -- requirements
Module: interconn_recv_fifo

---
 rtl/interconn_recv_fifo_pkg.sv | 14 +
 rtl/interconn_recv_fifo.sv | 112 +++++++++++
 tb/tb_interconn_recv_fifo.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/interconn_recv_fifo_pkg.sv
// rtl/interconn_recv_fifo_pkg.sv - shared MVU widths and receive entry layout
package interconn_recv_fifo_pkg;

    localparam int MVU_N     = 8;
    localparam int MVU_W     = 64;
    localparam int MVU_BADDR = 15;

    typedef struct packed {
        logic [MVU_N-1:0]     from;
        logic [MVU_BADDR-1:0] addr;
        logic [MVU_W-1:0]     word;
    } mvu_entry_t;

endpackage

// File: rtl/interconn_recv_fifo.sv
// rtl/interconn_recv_fifo.sv - first-word-fall-through receive FIFO between interconnect and local memory
module interconn_recv_fifo
    import interconn_recv_fifo_pkg::*;
#(
    parameter int N     = MVU_N,
    parameter int W     = MVU_W,
    parameter int BADDR = MVU_BADDR,
    parameter int DEPTH = 8,
    parameter int AFULL = DEPTH - 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             recv_en,
    input  logic [N-1:0]     recv_from,
    input  logic [BADDR-1:0] recv_addr,
    input  logic [W-1:0]     recv_word,
    input  logic             wr_ready,
    output logic             wr_en,
    output logic [N-1:0]     wr_from,
    output logic [BADDR-1:0] wr_addr,
    output logic [W-1:0]     wr_word,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             afull,
    output logic             ovf,
    output logic [7:0]       drop_cnt,
    input  logic             ovf_clr
);

    // Same field order as mvu_entry_t, re-sized to this instance's parameters.
    typedef struct packed {
        logic [N-1:0]     from;
        logic [BADDR-1:0] addr;
        logic [W-1:0]     word;
    } entry_t;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL);

    entry_t          mem_q [DEPTH];
    entry_t          head;
    logic [CW-1:0]   wptr_q, wptr_d;
    logic [CW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;
    logic            pop, push, drop;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);
    assign afull = (count_q >= AFULL_C);
    assign count = count_q;

    assign head    = mem_q[rptr_q[AW-1:0]];
    assign wr_en   = !empty;
    assign wr_from = head.from;
    assign wr_addr = head.addr;
    assign wr_word = head.word;

    // A pop frees the slot in the same edge, so a full FIFO still accepts.
    assign pop  = wr_en && wr_ready;
    assign push = recv_en && (!full || pop);
    assign drop = recv_en && full && !pop;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;
        if (push) wptr_d = wptr_q + CW'(1);
        if (pop)  rptr_d = rptr_q + CW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
        if (drop) begin
            ovf_d = 1'b1;
            if (ovf_clr)                  drop_cnt_d = 8'd1;
            else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end else if (ovf_clr) begin
            ovf_d      = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage is deliberately left out of reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= '{from: recv_from, addr: recv_addr, word: recv_word};
    end

    assign ovf      = ovf_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_interconn_recv_fifo.sv
// tb/tb_interconn_recv_fifo.sv - directed self-checking bench for interconn_recv_fifo
module tb_interconn_recv_fifo;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        recv_en = 1'b0;
    logic [7:0]  recv_from = '0;
    logic [14:0] recv_addr = '0;
    logic [63:0] recv_word = '0;
    logic        wr_ready = 1'b0;
    logic        wr_en;
    logic [7:0]  wr_from;
    logic [14:0] wr_addr;
    logic [63:0] wr_word;
    logic [3:0]  count;
    logic        empty, full, afull, ovf;
    logic [7:0]  drop_cnt;
    logic        ovf_clr = 1'b0;

    int total = 0;
    int bad   = 0;
    logic [63:0] q [$];

    interconn_recv_fifo dut (
        .clk(clk), .clr_n(clr_n), .recv_en(recv_en), .recv_from(recv_from),
        .recv_addr(recv_addr), .recv_word(recv_word), .wr_ready(wr_ready),
        .wr_en(wr_en), .wr_from(wr_from), .wr_addr(wr_addr), .wr_word(wr_word),
        .count(count), .empty(empty), .full(full), .afull(afull), .ovf(ovf),
        .drop_cnt(drop_cnt), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // One cycle with the given push/pop request, then idle inputs again.
    task automatic step(input logic en, input logic [63:0] word, input logic rdy);
        recv_en   = en;
        recv_word = word;
        recv_addr = word[14:0];
        recv_from = word[7:0];
        wr_ready  = rdy;
        tick();
        recv_en   = 1'b0;
        wr_ready  = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_wr_en", wr_en, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_afull", afull, 0);
        check("rst_count", count, 0);
        check("rst_ovf", {ovf, drop_cnt}, 0);
        clr_n = 1'b1;
        @(negedge clk);

        // single word, first-word-fall-through
        recv_en = 1'b1; recv_addr = 15'h0010; recv_word = 64'hDEAD_BEEF;
        recv_from = 8'b0000_0100; wr_ready = 1'b1;
        tick();
        recv_en = 1'b0;
        check("one_wr_en", wr_en, 1);
        check("one_addr", wr_addr, 15'h0010);
        check("one_word", wr_word, 64'hDEAD_BEEF);
        check("one_from", wr_from, 8'b0000_0100);
        tick();
        wr_ready = 1'b0;
        check("one_empty", empty, 1);

        // fill to full, watch afull, then overflow
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 64'h1000 + i, 1'b0);
            check($sformatf("fill_afull_%0d", i), afull, (i >= 6));
            check($sformatf("fill_count_%0d", i), count, i);
        end
        check("fill_full", full, 1);
        step(1'b1, 64'h9999, 1'b0);
        check("ovf_flag", ovf, 1);
        check("ovf_drop", drop_cnt, 1);
        check("ovf_count", count, 8);
        check("ovf_head", wr_word, 64'h1001);

        // clear overflow, then push+pop while full
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("clr_ovf", {ovf, drop_cnt}, 0);
        step(1'b1, 64'hAAAA, 1'b1);
        check("pp_count", count, 8);
        check("pp_ovf", ovf, 0);
        for (int i = 2; i <= 9; i++) begin
            check($sformatf("pp_out_%0d", i), wr_word, (i == 9) ? 64'hAAAA : 64'h1000 + i);
            step(1'b0, 0, 1'b1);
        end
        check("pp_empty", empty, 1);

        // saturate drop counter
        for (int i = 0; i < 8; i++) step(1'b1, 64'h2000 + i, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, 64'h3000 + i, 1'b0);
        check("sat_drop", drop_cnt, 255);
        check("sat_ovf", ovf, 1);
        check("sat_head", wr_word, 64'h2000);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("sat_clr", {ovf, drop_cnt}, 0);
        // overflow in the same cycle as clear wins
        recv_en = 1'b1; ovf_clr = 1'b1; tick(); recv_en = 1'b0; ovf_clr = 1'b0;
        check("race_ovf", ovf, 1);
        check("race_drop", drop_cnt, 1);

        // random traffic against a queue model from an empty FIFO
        clr_n = 1'b0; #1; clr_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 80; i++) begin
            logic en, rdy;
            logic pp;
            en  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 1) != 0);
            check($sformatf("rnd_count_%0d", i), count, q.size());
            if (q.size() > 0) check($sformatf("rnd_head_%0d", i), wr_word, q[0]);
            pp = (q.size() > 0) && rdy;
            if (pp) void'(q.pop_front());
            if (en && (q.size() < 8)) q.push_back(64'h4000 + i);
            step(en, 64'h4000 + i, rdy);
        end
        while (q.size() > 0) begin
            check("drain_head", wr_word, q[0]);
            void'(q.pop_front());
            step(1'b0, 0, 1'b1);
        end
        check("drain_empty", empty, 1);

        // asynchronous reset with 5 entries
        for (int i = 0; i < 5; i++) step(1'b1, 64'h5000 + i, 1'b0);
        check("ar_count_pre", count, 5);
        #2; clr_n = 1'b0; #1;
        check("ar_wr_en", wr_en, 0);
        check("ar_count", count, 0);
        check("ar_empty", empty, 1);
        @(negedge clk);
        clr_n = 1'b1;
        step(1'b1, 64'h6006, 1'b0);
        check("ar_resume_en", wr_en, 1);
        check("ar_resume_word", wr_word, 64'h6006);
        check("ar_resume_count", count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
